instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Sits on the consuming side of the PC register: reads `current_PC`, fetches the instruction at that address from instruction memory, and drives `new_PC` back into the PC register every cycle.
- The PC register loads `new_PC` on every `clk` edge and has no enable or reset. This block therefore holds the PC, initialises it, and sequences it.
- It presents fetched instructions downstream with a valid/ready handshake and redirects on branches.

Parameters:
- ADDR_WIDTH, 16, PC and instruction-memory address width.
- INSTR_WIDTH, 16, instruction word width.
- RESET_PC, 16'h0000, PC value forced during reset.
- PC_INC, 2, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- current_PC  input  ADDR_WIDTH  PC register output.
- new_PC  output  ADDR_WIDTH  next PC, to PC register input (combinational).
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  ADDR_WIDTH  read address; equals current_PC.
- imem_ready  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  INSTR_WIDTH  instruction word.
- instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
- instr_ready  input  1  downstream accepts instr this cycle.
- instr  output  INSTR_WIDTH  fetched instruction (registered).
- instr_pc  output  ADDR_WIDTH  address of instr (registered).
- branch_valid  input  1  redirect request, single-cycle pulse.
- branch_target  input  ADDR_WIDTH  redirect address.

Behaviour:
- Clock and reset: clock `clk`, reset `reset`. Reset is synchronous and active-high; all state is sampled on the rising edge of clk.
- Reset values: state = S_BOOT, instr_valid = 0, instr = 0, instr_pc = 0.
- During reset, imem_req = 0 and new_PC = RESET_PC. PC register therefore holds RESET_PC on the first cycle after reset deasserts.
- FSM states:
  - S_BOOT: exactly one cycle after reset. imem_req = 0, new_PC = current_PC. Then go to S_RUN.
  - S_RUN: steady state, no exit except reset.
- slot_free = !instr_valid || instr_ready.
- imem_req = (state == S_RUN) && slot_free && !branch_valid. imem_addr = current_PC at all times.
- Fetch completion (fire) = imem_req && imem_ready. Zero-wait memory allowed, i.e. ready in the same cycle as req.
  - On fire: instr <= imem_rdata, instr_pc <= current_PC, instr_valid <= 1.
  - On fire: new_PC = current_PC + PC_INC, modulo 2^ADDR_WIDTH, so 16'hFFFE wraps to 16'h0000.
- No fire and no branch: new_PC = current_PC, and instr_valid <= instr_valid && !instr_ready.
- Request stability: once imem_req is high without imem_ready, imem_req and imem_addr stay constant until fire. The only exceptions are a branch or reset.
- Throughput: one instruction per cycle with zero-wait memory and instr_ready held high.
- Backpressure: instr_valid && !instr_ready forces imem_req = 0. instr and instr_pc stay stable until accepted.
- Branch (branch_valid = 1 in S_RUN or S_BOOT):
  - new_PC = {branch_target[ADDR_WIDTH-1:1], 1'b0}; bit 0 is forced low.
  - instr_valid <= 0, which flushes any held instruction even if instr_ready is high that cycle.
  - imem_req = 0 that cycle, so any imem_ready is ignored.
  - The abandoned memory request is dropped without completion; memory must tolerate this.
- Priority: reset > branch_valid > fire > hold.
- Reset mid-fetch: the request drops immediately (same cycle), and new_PC = RESET_PC.

Decomposition:
- Shared package `fetch_pkg`: state enum (S_BOOT, S_RUN), default RESET_PC, PC_INC constants, and the ADDR_WIDTH/INSTR_WIDTH defaults reused by the PC register and decode stages.
- One natural sub-module, `pc_next_select`: combinational mux of RESET_PC / aligned branch target / current_PC + PC_INC / current_PC, driven by reset, branch_valid and fire.

Test Plan:
- Reset held for 3 cycles, then released, with a PC register model attached:
  - current_PC = 16'h0000.
  - imem_req low in the S_BOOT cycle, high on the next cycle.
  - imem_addr = 16'h0000.
- Zero-wait memory returning addr+16'h1000, instr_ready = 1:
  - instr sequence 16'h1000, 16'h1002, 16'h1004 on consecutive cycles.
  - instr_pc = 0, 2, 4.
  - instr_valid continuously high.
- Memory ready delayed 3 cycles per fetch:
  - imem_req/imem_addr stable for 3 cycles.
  - current_PC advances by 2 only after each imem_ready.
  - instr_valid pulses once per fetch.
- instr_ready low for 4 cycles with instr = 16'hABCD valid:
  - instr/instr_pc held.
  - imem_req = 0, current_PC frozen.
  - Resumes on the first cycle instr_ready = 1.
- branch_valid with branch_target = 16'h0123 during a pending request and a held instruction:
  - instr_valid = 0 next cycle.
  - current_PC = 16'h0122.
  - Next fetch address is 16'h0122.
- current_PC = 16'hFFFE, fire:
  - current_PC = 16'h0000 next cycle.
  - instr_pc = 16'hFFFE.
- Reset asserted while imem_req is high and not ready:
  - imem_req = 0 that cycle.
  - current_PC = RESET_PC next cycle.
  - instr_valid = 0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// fetch_pkg: shared fetch-stage types and default widths/constants
package fetch_pkg;
  localparam int FETCH_ADDR_WIDTH = 16;
  localparam int FETCH_INSTR_WIDTH = 16;
  localparam logic [FETCH_ADDR_WIDTH-1:0] FETCH_RESET_PC = 16'h0000;
  localparam int FETCH_PC_INC = 2;
  typedef enum logic {S_BOOT, S_RUN} state_t;
endpackage

// File: rtl/instruction_fetch_unit_pc_next_select.sv
// pc_next_select: picks the next PC with priority reset > branch > fire > hold
module pc_next_select
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = FETCH_RESET_PC,
  parameter int PC_INC = FETCH_PC_INC
) (
  input  logic                  reset,
  input  logic                  branch_valid,
  input  logic                  fire,
  input  logic [ADDR_WIDTH-1:0] current_pc,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] new_pc
);
  // branch targets are halfword aligned by clearing bit 0
  always_comb
    new_pc = reset        ? RESET_PC :
             branch_valid ? (branch_target & ~ADDR_WIDTH'(1)) :
             fire         ? current_pc + ADDR_WIDTH'(PC_INC) :
                            current_pc;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequences an external PC register and fetches instructions with valid/ready output
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = FETCH_RESET_PC,
  parameter int PC_INC = FETCH_PC_INC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  current_PC,
  output logic [ADDR_WIDTH-1:0]  new_PC,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target
);
  state_t state, state_next;
  logic slot_free, fire;
  // boot lasts one cycle so the PC register can settle on RESET_PC before fetching
  always_comb begin
    state_next = (state == S_BOOT) ? S_RUN : state;
    slot_free = !instr_valid || instr_ready;
    imem_req = !reset && (state == S_RUN) && slot_free && !branch_valid;
    imem_addr = current_PC;
    fire = imem_req && imem_ready;
  end
  // state register and output slot; a branch flushes the slot even if accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BOOT;
      instr_valid <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_next;
      if (branch_valid) instr_valid <= 1'b0;
      else if (fire) begin
        instr <= imem_rdata;
        instr_pc <= current_PC;
        instr_valid <= 1'b1;
      end else instr_valid <= instr_valid && !instr_ready;
    end
  end
  pc_next_select #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_PC(RESET_PC),
    .PC_INC(PC_INC)
  ) u_pc_next (
    .reset(reset),
    .branch_valid(branch_valid),
    .fire(fire),
    .current_pc(current_PC),
    .branch_target(branch_target),
    .new_pc(new_PC)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed table-driven check of the fetch unit with a PC register model
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] current_PC = 16'h5555;
  logic [15:0] new_PC, imem_addr, imem_rdata, instr, instr_pc;
  logic imem_req, instr_valid;
  logic imem_ready = 1'b0, instr_ready = 1'b0, branch_valid = 1'b0, ovr = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  int checks = 0, errors = 0;

  typedef struct {
    logic ovr, rdy, irdy, bv;
    logic [15:0] bt;
    logic req;
    logic [15:0] addr, npc;
    logic valid;
    logic [15:0] ins, ipc;
  } vec_t;
  vec_t tbl[24];

  always #5 clk = ~clk;

  // PC register: loads new_PC every edge, no reset or enable
  always @(posedge clk) current_PC <= new_PC;

  assign imem_rdata = ovr ? 16'hABCD : current_PC + 16'h1000;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .current_PC(current_PC), .new_PC(new_PC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .branch_valid(branch_valid),
    .branch_target(branch_target)
  );

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    //          ovr   rdy   irdy  bv    bt        req   addr      npc       v     instr     ipc
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0004, 1'b1, 16'h1000, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0006, 1'b1, 16'h1002, 16'h0002};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h0006, 1'b1, 16'h1004, 16'h0004};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h0006, 1'b0, 16'h1004, 16'h0004};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h0006, 1'b0, 16'h1004, 16'h0004};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h0008, 1'b0, 16'h1004, 16'h0004};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h0008, 1'b1, 16'h1006, 16'h0006};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h0008, 1'b0, 16'h1006, 16'h0006};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h0008, 1'b0, 16'h1006, 16'h0006};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h000A, 1'b0, 16'h1006, 16'h0006};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h000A, 16'h000A, 1'b1, 16'hABCD, 16'h0008};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h000A, 16'h000A, 1'b1, 16'hABCD, 16'h0008};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h000A, 16'h000A, 1'b1, 16'hABCD, 16'h0008};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h000A, 16'h000A, 1'b1, 16'hABCD, 16'h0008};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h000A, 16'h000C, 1'b1, 16'hABCD, 16'h0008};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0123, 1'b0, 16'h000C, 16'h0122, 1'b1, 16'h100A, 16'h000A};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0122, 16'h0122, 1'b0, 16'h100A, 16'h000A};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0123, 1'b0, 16'h0122, 16'h0122, 1'b0, 16'h100A, 16'h000A};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0122, 16'h0124, 1'b0, 16'h100A, 16'h000A};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0124, 16'hFFFE, 1'b1, 16'h1122, 16'h0122};
    tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 16'h0000, 1'b0, 16'h1122, 16'h0122};
    tbl[22] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0002, 1'b1, 16'h0FFE, 16'hFFFE};
    tbl[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0002, 1'b1, 16'h1000, 16'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 0, {15'd0, imem_req}, 16'h0000);
    chk("rst_npc", 0, new_PC, 16'h0000);
    reset = 1'b0;
    #1;
    chk("boot_pc", 0, current_PC, 16'h0000);
    chk("boot_req", 0, {15'd0, imem_req}, 16'h0000);
    chk("boot_addr", 0, imem_addr, 16'h0000);
    chk("boot_valid", 0, {15'd0, instr_valid}, 16'h0000);
    chk("boot_instr", 0, instr, 16'h0000);
    chk("boot_ipc", 0, instr_pc, 16'h0000);
    chk("boot_npc", 0, new_PC, 16'h0000);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      ovr = tbl[i].ovr;
      imem_ready = tbl[i].rdy;
      instr_ready = tbl[i].irdy;
      branch_valid = tbl[i].bv;
      branch_target = tbl[i].bt;
      #1;
      chk("req", i, {15'd0, imem_req}, {15'd0, tbl[i].req});
      chk("addr", i, imem_addr, tbl[i].addr);
      chk("cur_pc", i, current_PC, tbl[i].addr);
      chk("new_pc", i, new_PC, tbl[i].npc);
      chk("valid", i, {15'd0, instr_valid}, {15'd0, tbl[i].valid});
      chk("instr", i, instr, tbl[i].ins);
      chk("instr_pc", i, instr_pc, tbl[i].ipc);
    end

    // reset while a request is outstanding and memory is ready
    @(negedge clk);
    imem_ready = 1'b1;
    instr_ready = 1'b1;
    branch_valid = 1'b0;
    #1;
    chk("midrst_req_before", 0, {15'd0, imem_req}, 16'h0001);
    reset = 1'b1;
    #1;
    chk("midrst_req", 0, {15'd0, imem_req}, 16'h0000);
    chk("midrst_npc", 0, new_PC, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_pc", 0, current_PC, 16'h0000);
    chk("midrst_valid", 0, {15'd0, instr_valid}, 16'h0000);
    chk("midrst_instr", 0, instr, 16'h0000);
    chk("midrst_boot_req", 0, {15'd0, imem_req}, 16'h0000);
    @(negedge clk);
    #1;
    chk("midrst_run_req", 0, {15'd0, imem_req}, 16'h0001);
    chk("midrst_run_addr", 0, imem_addr, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
